// File: rtl/mcctl_fsm.sv
// rtl/mcctl_fsm.sv - multi-cycle main control FSM for the MIPS-subset datapath
// Optional addi support is compiled in with MCCTL_ADDI_EN.
module mcctl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [3:0] dec_state;
  logic       op_known;

  assign state = state_q;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_known = 1'b1;
`ifdef MCCTL_ADDI_EN
      OP_ADDI:                              op_known = 1'b1;
`endif
      default:                              op_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MCCTL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      // IR still holds the load/store opcode here, so it picks the memory direction.
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MCCTL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // During reset the outputs present the FETCH decode, but nothing commits.
  assign dec_state = rst ? S_FETCH : state_q;

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (dec_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready & ~rst;
        pc_write  = mem_ready & ~rst;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMMSH;
        illegal_op = ~op_known;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
`ifdef MCCTL_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mcctl_fsm.sv
// tb/tb_mcctl_fsm.sv - randomized self-checking bench for mcctl_fsm
module tb_mcctl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, branch;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       reg_dst, mem_to_reg, reg_write, retire, illegal_op;
  logic [3:0] state;
  logic [17:0] obs;

  int total = 0;
  int bad   = 0;

  typedef string sq_t[$];

  mcctl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .retire(retire), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {mem_read, mem_write, iord, ir_write, pc_write, branch, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write,
                retire, illegal_op};

  // Phase route each opcode walks through, by name.
  function automatic sq_t route(logic [5:0] op);
    sq_t r;
    r.push_back("FETCH");
    r.push_back("DECODE");
    case (op)
      6'b000000: begin r.push_back("EXEC"); r.push_back("ALUWB"); end
      6'b100011: begin r.push_back("MEMADR"); r.push_back("MEMRD"); r.push_back("MEMWB"); end
      6'b101011: begin r.push_back("MEMADR"); r.push_back("MEMWR"); end
      6'b000100: r.push_back("BRANCH");
      6'b000010: r.push_back("JUMP");
`ifdef MCCTL_ADDI_EN
      6'b001000: begin r.push_back("ADDIEX"); r.push_back("ADDIWB"); end
`endif
      default: ;
    endcase
    return r;
  endfunction

  function automatic int code_of(string s);
    if (s == "FETCH")  return 0;
    if (s == "DECODE") return 1;
    if (s == "MEMADR") return 2;
    if (s == "MEMRD")  return 3;
    if (s == "MEMWB")  return 4;
    if (s == "MEMWR")  return 5;
    if (s == "EXEC")   return 6;
    if (s == "ALUWB")  return 7;
    if (s == "BRANCH") return 8;
    if (s == "ADDIEX") return 9;
    if (s == "ADDIWB") return 10;
    if (s == "JUMP")   return 11;
    return -1;
  endfunction

  function automatic bit legal(logic [5:0] op);
    sq_t r = route(op);
    return r.size() > 2;
  endfunction

  function automatic int latency(logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b000000, 6'b101011: return 4;
      6'b000100, 6'b000010: return 3;
`ifdef MCCTL_ADDI_EN
      6'b001000: return 4;
`endif
      default: return 2;
    endcase
  endfunction

  function automatic logic [17:0] exp_ctl(string ph, logic mr, logic [5:0] op);
    logic mrd = 0, mwr = 0, io = 0, irw = 0, pcw = 0, br = 0;
    logic [1:0] pcs = 0, asb = 0, aop = 0;
    logic asa = 0, rd = 0, m2r = 0, rw = 0, ret = 0, ill = 0;
    if (ph == "FETCH")       begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
    else if (ph == "DECODE") begin asb = 2'b11; ill = !legal(op); end
    else if (ph == "MEMADR") begin asa = 1; asb = 2'b10; end
    else if (ph == "MEMRD")  begin mrd = 1; io = 1; end
    else if (ph == "MEMWB")  begin m2r = 1; rw = 1; ret = 1; end
    else if (ph == "MEMWR")  begin mwr = 1; io = 1; ret = mr; end
    else if (ph == "EXEC")   begin asa = 1; aop = 2'b10; end
    else if (ph == "ALUWB")  begin rd = 1; rw = 1; ret = 1; end
    else if (ph == "BRANCH") begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; ret = 1; end
    else if (ph == "JUMP")   begin pcs = 2'b10; pcw = 1; ret = 1; end
    else if (ph == "ADDIEX") begin asa = 1; asb = 2'b10; end
    else if (ph == "ADDIWB") begin rw = 1; ret = 1; end
    return {mrd, mwr, io, irw, pcw, br, pcs, asa, asb, aop, rd, m2r, rw, ret, ill};
  endfunction

  task automatic check_cycle(string ph, logic [5:0] op, string tag);
    logic [17:0] want;
    want = exp_ctl(ph, mem_ready, op);
    total++;
    if (state !== 4'(code_of(ph))) begin
      bad++;
      $display("FAIL %s state got=%0d want=%0d (%s)", tag, state, code_of(ph), ph);
    end
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s ctl in %s got=%b want=%b", tag, ph, obs, want);
    end
    total++;
    if ((mem_write && reg_write) || (pc_write && branch)) begin
      bad++;
      $display("FAIL %s exclusive strobes got mw=%b rw=%b pw=%b br=%b want no pair", tag,
               mem_write, reg_write, pc_write, branch);
    end
  endtask

  // Runs one instruction from FETCH with fs FETCH stalls and ms memory-phase stalls.
  task automatic run_instr(logic [5:0] op, int fs, int ms, string tag);
    sq_t r;
    int cyc = 0;
    int rets = 0;
    int want_lat;
    r = route(op);
    opcode = op;
    foreach (r[i]) begin
      bit st;
      int n;
      st = (r[i] == "FETCH") || (r[i] == "MEMRD") || (r[i] == "MEMWR");
      n  = (r[i] == "FETCH") ? fs : (st ? ms : 0);
      for (int k = 0; k <= n; k++) begin
        mem_ready = st ? (k == n) : 1'($urandom_range(0, 1));
        #2;
        check_cycle(r[i], op, tag);
        if (retire === 1'b1) rets++;
        cyc++;
        @(posedge clk);
        #1;
      end
    end
    want_lat = latency(op) + fs + ((op == 6'b100011 || op == 6'b101011) ? ms : 0);
    total++;
    if (cyc != want_lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", tag, cyc, want_lat);
    end
    total++;
    if (rets != (legal(op) ? 1 : 0)) begin
      bad++;
      $display("FAIL %s retire count got=%0d want=%0d", tag, rets, legal(op) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    check_cycle("FETCH", opcode, "reset");
    mem_ready = 1'b1;
    #1;
    total++;
    if (retire !== 1'b0 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL reset pulses got retire=%b illegal=%b want 0 0", retire, illegal_op);
    end
    @(posedge clk);
    #1;
    total++;
    if (state !== 4'd0) begin
      bad++;
      $display("FAIL reset_with_ready state got=%0d want=0", state);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    bit saw_rw = 0;
    opcode = 6'b100011;
    mem_ready = 1'b1; #2; check_cycle("FETCH", opcode, "rst_stall");
    @(posedge clk); #1; #2; check_cycle("DECODE", opcode, "rst_stall");
    @(posedge clk); #1; #2; check_cycle("MEMADR", opcode, "rst_stall");
    @(posedge clk); #1;
    mem_ready = 1'b0; #2; check_cycle("MEMRD", opcode, "rst_stall");
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    if (reg_write === 1'b1 || retire === 1'b1) saw_rw = 1;
    total++;
    if (obs !== exp_ctl("FETCH", 1'b0, opcode)) begin
      bad++;
      $display("FAIL rst_stall ctl during reset got=%b want=%b", obs, exp_ctl("FETCH", 1'b0, opcode));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    if (reg_write === 1'b1 || retire === 1'b1) saw_rw = 1;
    total++;
    if (state !== 4'd0) begin
      bad++;
      $display("FAIL rst_stall next state got=%0d want=0", state);
    end
    total++;
    if (saw_rw) begin
      bad++;
      $display("FAIL rst_stall reg_write/retire got=1 want=0");
    end
    #1;
    run_instr(6'b000000, 0, 0, "after_rst");
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b000010, 6'b001000, 6'b111111, 6'b000000};
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op;
      int idx;
      idx = int'($urandom_range(0, 7));
      op = (idx == 7) ? 6'($urandom) : ops[idx];
      run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    run_instr(6'b000000, 0, 0, "rtype");
    run_instr(6'b100011, 0, 2, "lw_stall");
    run_instr(6'b101011, 3, 0, "sw_fetch_stall");
    run_instr(6'b000100, 0, 0, "beq");
    run_instr(6'b000010, 0, 0, "j");
    run_instr(6'b111111, 0, 0, "illegal");
    run_instr(6'b001000, 1, 0, "addi");
    run_instr(6'b101011, 0, 2, "sw_memwr_stall");
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
